// File: rtl/pc_flow_ctrl.sv
// PC flow controller: selects the next-PC source, gates PC writes on stalls,
// flushes the IF/ID slots left on the wrong path after a redirect, and keeps
// redirect/stall performance counters plus a sticky illegal-select flag.
module pc_flow_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pcsel_in,
  input  logic             valid_id,
  input  logic             stall_req,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic [1:0]       pc_mux,
  output logic             flush_id,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_sel
);

  localparam logic [1:0] SelSeq   = 2'b00;
  localparam logic [1:0] SelJal   = 2'b01;
  localparam logic [1:0] SelBr    = 2'b10;
  localparam logic [1:0] SelReset = 2'b11;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold,
    StFlush
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic       redirect;
  logic       err_set;
  logic       redirect_inc;

  // An illegal select (11) is not a redirect; it falls through as sequential.
  assign redirect = valid_id && (pcsel_in == SelJal || pcsel_in == SelBr);

  // pcsel_in is only consumed in RUN, so only there can it flag an error.
  assign err_set = (state_q == StRun) && valid_id && (pcsel_in == SelReset);

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pc_we    = 1'b1;
    pc_mux   = SelSeq;
    flush_id = 1'b0;
    case (state_q)
      StBoot: begin
        pc_mux   = SelReset;
        flush_id = 1'b1;
        pc_we    = !stall_req;
        if (!stall_req) state_d = StRun;
      end
      StRun: begin
        if (!stall_req) begin
          if (redirect) begin
            pc_mux   = pcsel_in;
            flush_id = 1'b1;
            state_d  = StFlush;
          end
        end else begin
          pc_we = 1'b0;
          // Remember the redirect until the stall drops.
          if (redirect) begin
            pend_d  = pcsel_in;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (stall_req) begin
          pc_we = 1'b0;
        end else begin
          pc_mux   = pend_q;
          flush_id = 1'b1;
          state_d  = StFlush;
        end
      end
      StFlush: begin
        // Second wrong-path slot from the 1-cycle instruction BRAM latency.
        flush_id = 1'b1;
        pc_we    = !stall_req;
        if (!stall_req) state_d = StRun;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
    // Reset forces the reset-vector fetch regardless of state or stall.
    if (rst) begin
      pc_mux   = SelReset;
      flush_id = 1'b1;
      pc_we    = 1'b1;
    end
  end

  assign redirect_inc = pc_we && (pc_mux == SelJal || pc_mux == SelBr);

  // State and pending-select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pend_q  <= SelSeq;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else if (cnt_clr) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (redirect_inc) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (!pc_we)       stall_cnt    <= stall_cnt + CNT_W'(1);
    end
  end

  // Sticky illegal-select flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else if (err_set) begin
      err_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl. Counters are 3 bits wide here so that
// wrap-around is reachable in a few cycles.
module tb_pc_flow_ctrl;

  localparam int unsigned CntW = 3;

  logic            clk;
  logic            rst;
  logic [1:0]      pcsel_in;
  logic            valid_id;
  logic            stall_req;
  logic            cnt_clr;
  logic            pc_we;
  logic [1:0]      pc_mux;
  logic            flush_id;
  logic [CntW-1:0] redirect_cnt;
  logic [CntW-1:0] stall_cnt;
  logic            err_sel;

  int checks = 0;
  int errors = 0;

  pc_flow_ctrl #(
    .CNT_W (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pcsel_in     (pcsel_in),
    .valid_id     (valid_id),
    .stall_req    (stall_req),
    .cnt_clr      (cnt_clr),
    .pc_we        (pc_we),
    .pc_mux       (pc_mux),
    .flush_id     (flush_id),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt),
    .err_sel      (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int rc, input int sc, input logic er);
    check_val({tag, ".rcnt"}, 32'(redirect_cnt), 32'(rc));
    check_val({tag, ".scnt"}, 32'(stall_cnt), 32'(sc));
    check_val({tag, ".err"}, 32'(err_sel), 32'(er));
  endtask

  // Drive one cycle of inputs, check the combinational outputs mid-cycle,
  // then advance to just after the next rising edge.
  task automatic step(input string tag, input logic s, input logic v, input logic [1:0] sel,
                      input logic clr, input logic ewe, input logic [1:0] emux,
                      input logic efl);
    stall_req = s;
    valid_id  = v;
    pcsel_in  = sel;
    cnt_clr   = clr;
    #4;
    check_val({tag, ".we"}, 32'(pc_we), 32'(ewe));
    check_val({tag, ".mux"}, 32'(pc_mux), 32'(emux));
    check_val({tag, ".flush"}, 32'(flush_id), 32'(efl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    pcsel_in  = 2'b00;
    valid_id  = 1'b0;
    stall_req = 1'b1;
    cnt_clr   = 1'b0;
    @(posedge clk);
    #1;
    // Reset outputs hold even with a stall request present.
    check_val("rst.we", 32'(pc_we), 32'd1);
    check_val("rst.mux", 32'(pc_mux), 32'd3);
    check_val("rst.flush", 32'(flush_id), 32'd1);
    check_cnt("rst", 0, 0, 1'b0);
    stall_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Boot then sequential run
    step("boot", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1);
    step("run0", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    step("run1", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    check_cnt("run", 0, 0, 1'b0);

    // Unstalled branch redirect
    step("br", 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1);
    step("br.fl", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
    step("br.run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    check_cnt("br", 1, 0, 1'b0);

    // Clear beats a same-cycle redirect increment
    step("clr.jal", 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1);
    step("clr.fl", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
    check_cnt("clr", 0, 0, 1'b0);
    step("clr.run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);

    // Held JAL redirect over 3 stall cycles; HOLD ignores a second request
    step("hold0", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
    step("hold1", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
    step("hold2", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    step("hold.go", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1);
    step("hold.fl", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
    check_cnt("hold", 1, 3, 1'b0);
    step("hold.run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);

    // Stall during FLUSH; a redirect in FLUSH is ignored
    step("fs.br", 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1);
    step("fs.st0", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1);
    step("fs.st1", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
    step("fs.exit", 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1);
    step("fs.run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    check_cnt("fs", 2, 5, 1'b0);

    // stall_cnt wraps: 5 + 4 = 9 -> 1 modulo 8
    for (int i = 0; i < 4; i++) begin
      step("wrap", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    end
    check_cnt("wrap", 2, 1, 1'b0);

    // Illegal select: sequential, no flush, sticky error survives clear
    step("ill", 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0);
    check_cnt("ill", 2, 1, 1'b1);
    step("ill.clr", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0);
    check_cnt("ill.clr", 0, 0, 1'b1);
    step("ill.run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    check_cnt("ill.hold", 0, 0, 1'b1);

    // Reset asserted in the middle of HOLD discards the pending redirect
    step("rh.enter", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0);
    stall_req = 1'b1;
    valid_id  = 1'b0;
    #2;
    check_val("rh.held.we", 32'(pc_we), 32'd0);
    rst = 1'b1;
    #1;
    check_val("rh.rst.we", 32'(pc_we), 32'd1);
    check_val("rh.rst.mux", 32'(pc_mux), 32'd3);
    check_val("rh.rst.flush", 32'(flush_id), 32'd1);
    check_cnt("rh.rst", 0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rh.boot", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("rh.run", 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
    end
    check_cnt("rh.end", 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_flow_ctrl.md
PC_FLOW_CTRL -- requirements
Module: pc_flow_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the performance counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 pcsel_in  input  2  redirect request from PC-select logic: 00 sequential, 01 JAL target, 10 branch/JALR target, 11 illegal.
REQ-005 valid_id  input  1  the ID-stage instruction is real (not a bubble).
REQ-006 stall_req  input  1  pipeline stall request (load-use, memory wait).
REQ-007 cnt_clr  input  1  synchronous clear of both counters.
REQ-008 pc_we  output  1  PC register write enable.
REQ-009 pc_mux  output  2  PC next-value select: 00 PC+4, 01 JAL target, 10 branch/JALR target, 11 reset vector.
REQ-010 flush_id  output  1  forces the next IF/ID register value to a bubble.
REQ-011 redirect_cnt  output  CNT_W  number of applied redirects.
REQ-012 stall_cnt  output  CNT_W  number of cycles with pc_we=0.
REQ-013 err_sel  output  1  sticky flag: illegal pcsel_in was seen.

Function
REQ-014 Define redirect = valid_id AND pcsel_in in {01,10}; pcsel_in=11 with valid_id=1 SHALL be treated as 00 and SHALL set err_sel.
REQ-015 FSM states: BOOT, RUN, HOLD, FLUSH; outputs are decoded combinationally from the state and inputs.
REQ-016 BOOT: pc_mux=11, flush_id=1, pc_we=NOT stall_req; next state is RUN if stall_req=0, otherwise BOOT.
REQ-017 RUN, stall_req=0, no redirect: pc_mux=00, pc_we=1, flush_id=0; remain in RUN.
REQ-018 RUN, stall_req=0, redirect: pc_mux=pcsel_in, pc_we=1, flush_id=1; next state FLUSH.
REQ-019 RUN, stall_req=1, no redirect: pc_we=0, flush_id=0, pc_mux=00; remain in RUN.
REQ-020 RUN, stall_req=1, redirect: pc_we=0, flush_id=0; capture pend_sel<=pcsel_in; next state HOLD.
REQ-021 HOLD: pcsel_in and valid_id are ignored. While stall_req=1: pc_we=0, flush_id=0. When stall_req=0: pc_mux=pend_sel, pc_we=1, flush_id=1; next state FLUSH.
REQ-022 FLUSH covers the second wrong-path slot caused by the 1-cycle instruction BRAM latency: flush_id=1, pc_mux=00, pc_we=NOT stall_req, and redirect requests are ignored.
REQ-023 FLUSH exit: next state RUN when stall_req=0; otherwise remain in FLUSH.
REQ-024 Redirect latency: the target is selected in the same cycle as the redirect when unstalled, and in the first cycle with stall_req=0 when the redirect is held.
REQ-025 redirect_cnt SHALL increment by 1 in each cycle where pc_we=1 and pc_mux is 01 or 10.
REQ-026 stall_cnt SHALL increment by 1 in each cycle where pc_we=0, in any state.
REQ-027 Both counters wrap modulo 2^CNT_W.
REQ-028 cnt_clr=1 zeroes both counters on the next edge and has priority over a same-cycle increment.
REQ-029 err_sel stays set until reset; it is not affected by cnt_clr.
REQ-030 At most one redirect is pending; HOLD never accepts a second redirect.

Reset
REQ-031 Asserting rst SHALL immediately force state BOOT, pend_sel=00, redirect_cnt=0, stall_cnt=0, err_sel=0, including mid-HOLD or mid-FLUSH.
REQ-032 Outputs while rst=1: pc_mux=11, flush_id=1, pc_we=1; a pending redirect is discarded.
REQ-033 After rst deasserts, the first edge completes BOOT (REQ-016).

Verification
REQ-034 Release reset, hold stall_req=0, valid_id=0 -> one cycle with pc_mux=11, flush_id=1; then RUN with pc_mux=00, pc_we=1 every cycle; counters remain 0.
REQ-035 In RUN, pulse valid_id=1 with pcsel_in=10 for one cycle -> that cycle pc_mux=10, pc_we=1, flush_id=1; next cycle flush_id=1, pc_mux=00; then flush_id=0; redirect_cnt=1.
REQ-036 In RUN, set stall_req=1 for 3 cycles while valid_id=1 and pcsel_in=01 in the first stall cycle -> 3 cycles with pc_we=0; cycle 4 has pc_mux=01, pc_we=1, flush_id=1; then one FLUSH cycle; stall_cnt=3, redirect_cnt=1.
REQ-037 Apply stall_req=1 during FLUSH for 2 cycles -> flush_id stays 1 and pc_we=0 for 2 cycles; FLUSH exits on the first cycle with stall_req=0.
REQ-038 Drive valid_id=1 with pcsel_in=11 -> pc_mux=00, no flush, err_sel=1 and held; cnt_clr=1 does not clear err_sel.
REQ-039 Assert rst mid-HOLD -> outputs immediately switch to the reset values; after release the pending redirect is never applied (pc_mux never 01/10 without a new request).
